morse_letter_sequencer: RTL and testbench

//  Controller downstream of the dot/dash classifier. Collects 1-cycle dot/dash pulses into a letter code.

---
 rtl/morse_letter_sequencer_if.sv | 21 ++
 rtl/morse_letter_sequencer.sv | 117 +++++++++++
 tb/tb_morse_letter_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/morse_letter_sequencer_if.sv
// morse_letter_sequencer_if: symbol inputs, letter handshake and event pulses between
// the dot/dash classifier, the letter sequencer and the character consumer.
interface morse_letter_sequencer_if;
   logic       btn_level;
   logic       dot;
   logic       dash;
   logic       letter_ack;
   logic [4:0] code_out;
   logic [2:0] len_out;
   logic       letter_valid;
   logic       word_gap;
   logic       err;
   modport master (
      input  btn_level, dot, dash, letter_ack,
      output code_out, len_out, letter_valid, word_gap, err
   );
   modport slave (
      output btn_level, dot, dash, letter_ack,
      input  code_out, len_out, letter_valid, word_gap, err
   );
endinterface

// File: rtl/morse_letter_sequencer.sv
// morse_letter_sequencer: gathers dot/dash pulses into a letter, hands it over by valid/ack
// and flags word boundaries from key-release silence counted in prescaler ticks.
module morse_letter_sequencer #(
   parameter int TICK_FINAL       = 4_999_999,
   parameter int LETTER_GAP_TICKS = 6,
   parameter int WORD_GAP_TICKS   = 14
) (
   input logic clk,
   input logic reset_n,
   morse_letter_sequencer_if.master bus
);
   localparam int PW = (TICK_FINAL > 0) ? $clog2(TICK_FINAL + 1) : 1;
   localparam int GW = $clog2(WORD_GAP_TICKS + 1);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] COLLECT   = 3'd1;
   localparam logic [2:0] HOLD      = 3'd2;
   localparam logic [2:0] WAIT_WORD = 3'd3;
   localparam logic [2:0] DISCARD   = 3'd4;
   logic [2:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [4:0]    shift_q, shift_d, code_q, code_d;
   logic [2:0]    cnt_q, cnt_d, len_q, len_d;
   logic          valid_q, valid_d, wg_q, wg_d, err_q, err_d;
   logic          tick, sym, letter_hit, word_hit;
   logic [4:0]    first;
   always_comb begin
      tick = pre_q == PW'(TICK_FINAL);
      pre_d = tick ? '0 : pre_q + 1'b1;
      sym = bus.dot ^ bus.dash;
      // any key activity, even a rejected symbol, restarts the silence measurement
      gap_d = (bus.btn_level | bus.dot | bus.dash) ? '0
            : (tick && gap_q != GW'(WORD_GAP_TICKS)) ? gap_q + 1'b1 : gap_q;
      letter_hit = gap_d == GW'(LETTER_GAP_TICKS);
      word_hit = gap_d >= GW'(WORD_GAP_TICKS);
      first = {4'b0, bus.dash};
      state_d = state_q;
      shift_d = shift_q;
      cnt_d = cnt_q;
      code_d = code_q;
      len_d = len_q;
      valid_d = valid_q;
      wg_d = 1'b0;
      err_d = bus.dot & bus.dash;
      case (state_q)
         IDLE: if (sym) begin
            shift_d = first;
            cnt_d = 3'd1;
            state_d = COLLECT;
         end
         COLLECT: if (sym && cnt_q == 3'd5) begin
            err_d = 1'b1;
            shift_d = '0;
            cnt_d = '0;
            state_d = DISCARD;
         end else if (sym) begin
            shift_d = shift_q | (first << cnt_q);
            cnt_d = cnt_q + 3'd1;
         end else if (letter_hit) begin
            code_d = shift_q;
            len_d = cnt_q;
            valid_d = 1'b1;
            shift_d = '0;
            cnt_d = '0;
            state_d = HOLD;
         end
         HOLD: begin
            err_d = err_d | sym;
            // a late ack may find the word gap already elapsed: report it straight away
            if (bus.letter_ack) begin
               valid_d = 1'b0;
               wg_d = word_hit;
               state_d = word_hit ? IDLE : WAIT_WORD;
            end
         end
         WAIT_WORD: if (sym) begin
            shift_d = first;
            cnt_d = 3'd1;
            state_d = COLLECT;
         end else if (word_hit) begin
            wg_d = 1'b1;
            state_d = IDLE;
         end
         DISCARD: if (letter_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         pre_q <= '0;
         gap_q <= '0;
         shift_q <= '0;
         cnt_q <= '0;
         code_q <= '0;
         len_q <= '0;
         valid_q <= 1'b0;
         wg_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q <= pre_d;
         gap_q <= gap_d;
         shift_q <= shift_d;
         cnt_q <= cnt_d;
         code_q <= code_d;
         len_q <= len_d;
         valid_q <= valid_d;
         wg_q <= wg_d;
         err_q <= err_d;
      end
   assign bus.code_out = code_q;
   assign bus.len_out = len_q;
   assign bus.letter_valid = valid_q;
   assign bus.word_gap = wg_q;
   assign bus.err = err_q;
endmodule

// File: tb/tb_morse_letter_sequencer.sv
// tb_morse_letter_sequencer: random and directed stimulus checked every cycle against a
// queue-based letter model, plus hand-computed timing and code expectations.
module tb_morse_letter_sequencer;
   localparam int TF = 3, L = 3, W = 7;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int n_chk = 0, n_fail = 0;
   int sym_q[$];
   bit holding, discarding, awaiting;
   int silent, cyc;
   logic [4:0] e_code;
   logic [2:0] e_len;
   bit e_valid, e_wg, e_err;
   bit btn;
   morse_letter_sequencer_if bus();
   morse_letter_sequencer #(.TICK_FINAL(TF), .LETTER_GAP_TICKS(L), .WORD_GAP_TICKS(W)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic mreset();
      sym_q.delete();
      holding = 0;
      discarding = 0;
      awaiting = 0;
      silent = 0;
      cyc = 0;
      e_code = '0;
      e_len = '0;
      e_valid = 0;
      e_wg = 0;
      e_err = 0;
   endtask
   // one clock of the letter model: silence in whole ticks, the letter as a queue of symbols
   task automatic mstep();
      bit tick, sym, d, h;
      int c;
      d = bus.dot;
      h = bus.dash;
      tick = (cyc % (TF + 1)) == TF;
      cyc++;
      sym = d != h;
      if (bus.btn_level || d || h) silent = 0;
      else if (tick) silent++;
      e_err = d && h;
      e_wg = 0;
      if (holding) begin
         if (sym) e_err = 1;
         if (bus.letter_ack) begin
            holding = 0;
            e_valid = 0;
            if (silent >= W) e_wg = 1;
            else awaiting = 1;
         end
      end else if (discarding) begin
         if (silent == L) discarding = 0;
      end else if (sym_q.size() > 0) begin
         if (sym && sym_q.size() == 5) begin
            e_err = 1;
            sym_q.delete();
            discarding = 1;
         end else if (sym) sym_q.push_back(int'(h));
         else if (silent == L) begin
            c = 0;
            foreach (sym_q[i]) c += sym_q[i] << i;
            e_code = 5'(c);
            e_len = 3'(sym_q.size());
            e_valid = 1;
            holding = 1;
            sym_q.delete();
         end
      end else if (sym) begin
         sym_q.push_back(int'(h));
         awaiting = 0;
      end else if (awaiting && silent >= W) begin
         e_wg = 1;
         awaiting = 0;
      end
   endtask
   initial begin
      mreset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) mreset();
         else mstep();
      end
   end
   initial forever begin
      @(negedge clk);
      chk("code_out", bus.code_out, e_code);
      chk("len_out", bus.len_out, e_len);
      chk("letter_valid", bus.letter_valid, e_valid);
      chk("word_gap", bus.word_gap, e_wg);
      chk("err", bus.err, e_err);
   end
   task automatic drive(bit d, bit h, bit a, bit b);
      bus.dot = d;
      bus.dash = h;
      bus.letter_ack = a;
      bus.btn_level = b;
      @(negedge clk);
   endtask
   task automatic idle(int n);
      repeat (n) drive(0, 0, 0, 0);
   endtask
   task automatic wait_valid(int lim);
      int k = 0;
      while (!bus.letter_valid && k < lim) begin
         drive(0, 0, 0, 0);
         k++;
      end
      chk("valid_wait", bus.letter_valid, 1);
   endtask
   task automatic async_reset();
      bus.dot = 0;
      bus.dash = 0;
      bus.letter_ack = 0;
      bus.btn_level = 0;
      btn = 0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_code", bus.code_out, 0);
      chk("rst_len", bus.len_out, 0);
      chk("rst_valid", bus.letter_valid, 0);
      chk("rst_wg", bus.word_gap, 0);
      chk("rst_err", bus.err, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask
   initial begin
      bus.dot = 0;
      bus.dash = 0;
      bus.letter_ack = 0;
      bus.btn_level = 0;
      btn = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      // 'A': dot at cycle 0, dash at cycle 8, letter after ticks 11/15/19
      drive(1, 0, 0, 0);
      idle(7);
      drive(0, 1, 0, 0);
      idle(10);
      chk("A_early", bus.letter_valid, 0);
      idle(1);
      chk("A_valid", bus.letter_valid, 1);
      chk("A_code", bus.code_out, 5'b00010);
      chk("A_len", bus.len_out, 2);
      idle(20);
      chk("A_held", bus.code_out, 5'b00010);
      drive(0, 0, 1, 0);
      chk("late_ack_valid", bus.letter_valid, 0);
      chk("late_ack_wg", bus.word_gap, 1);
      idle(1);
      chk("late_ack_wg_end", bus.word_gap, 0);
      // 'E' at cycle 42, ack at once, word gap after the 7th tick (cycle 67)
      drive(1, 0, 0, 0);
      idle(8);
      chk("E_early", bus.letter_valid, 0);
      idle(1);
      chk("E_valid", bus.letter_valid, 1);
      chk("E_len", bus.len_out, 1);
      drive(0, 0, 1, 0);
      chk("E_ack", bus.letter_valid, 0);
      idle(14);
      chk("wg_early", bus.word_gap, 0);
      idle(1);
      chk("wg_pulse", bus.word_gap, 1);
      idle(1);
      chk("wg_single", bus.word_gap, 0);
      // symbol in HOLD is dropped
      repeat (3) drive(1, 0, 0, 0);
      wait_valid(40);
      chk("S_code", bus.code_out, 0);
      chk("S_len", bus.len_out, 3);
      drive(0, 1, 0, 0);
      chk("hold_err", bus.err, 1);
      chk("hold_code", bus.code_out, 0);
      chk("hold_len", bus.len_out, 3);
      drive(0, 0, 1, 0);
      chk("hold_ack", bus.letter_valid, 0);
      // dash in WAIT_WORD starts a new letter without a word gap
      drive(0, 1, 0, 0);
      wait_valid(40);
      chk("T_code", bus.code_out, 5'b00001);
      drive(0, 0, 1, 0);
      idle(20);
      // six symbols overflow the letter
      repeat (5) drive(1, 0, 0, 0);
      chk("five_no_err", bus.err, 0);
      drive(1, 0, 0, 0);
      chk("six_err", bus.err, 1);
      idle(40);
      // a held key freezes silence between dot and dash
      drive(1, 0, 0, 0);
      repeat (40) drive(0, 0, 0, 1);
      drive(0, 1, 0, 0);
      wait_valid(40);
      chk("btn_code", bus.code_out, 5'b00010);
      chk("btn_len", bus.len_out, 2);
      drive(0, 0, 1, 0);
      idle(40);
      // dot+dash together is rejected without touching the letter
      drive(1, 0, 0, 0);
      drive(1, 1, 0, 0);
      chk("both_err", bus.err, 1);
      drive(0, 1, 0, 0);
      wait_valid(40);
      chk("both_len", bus.len_out, 2);
      chk("both_code", bus.code_out, 5'b00010);
      async_reset();
      idle(30);
      chk("post_rst_valid", bus.letter_valid, 0);
      for (int s = 0; s < 40; s++) begin
         int dens;
         dens = $urandom_range(2, 15);
         for (int i = 0; i < 100; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (btn ? $urandom_range(0, 19) == 0 : $urandom_range(0, 99) == 0) btn = ~btn;
            drive(r < dens || r == 99, (r >= dens && r < 2 * dens) || r == 99,
                  $urandom_range(0, 9) == 0, btn);
         end
         if (s % 10 == 9) async_reset();
      end
      idle(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
